fwd_unit_param: RTL and testbench
=================================

Name: fwd_unit_param

Overview:
- Parametrised successor to the two-operand EX-stage forwarding mux-select logic.
- Generalised in register-address width, data width and source-operand count. Returns the forwarded value as well as the select.
- Adds a history buffer of recently retired WB writes, for register files without internal write-through, plus a one-cycle load-use stall FSM.
- Sits between the EX stage operand muxes and the hazard/pipeline-freeze logic.

Parameters:
REG_AW, 4, register address width
DATA_W, 32, operand data width
NUM_SRC, 2, number of EX source operands served
HIST_DEPTH, 2, retired-write history entries (1..4)
NO_FWD_REG, 15, register address never forwarded (PC); its select is always 2'b00

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
freeze  in  1  global pipeline freeze; holds FSM state and history
ex_src  in  NUM_SRC*REG_AW  EX source addresses, operand i at [i*REG_AW +: REG_AW]
ex_src_vld  in  NUM_SRC  operand i actually read
mem_wb_en  in  1  MEM-stage instruction writes back
mem_dest  in  REG_AW  MEM-stage destination
mem_is_load  in  1  MEM-stage instruction is a load (result not yet available)
mem_alu  in  DATA_W  MEM-stage ALU result
wb_wb_en  in  1  WB-stage write enable
wb_dest  in  REG_AW  WB destination
wb_data  in  DATA_W  WB write data
sel  out  NUM_SRC*2  per-operand select: 00 regfile, 01 MEM, 10 WB, 11 history
fwd_data  out  NUM_SRC*DATA_W  per-operand forwarded value; 0 when sel=00
hazard_stall  out  1  load-use stall request to the hazard unit

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE, all history valid bits cleared, stats counters cleared. While rst is low, sel=0, fwd_data=0 and hazard_stall=0 regardless of inputs.
- Per-operand select is combinational, zero latency. Priority for operand i when ex_src_vld[i]=1 and ex_src[i]!=NO_FWD_REG:
  1) mem_wb_en && mem_dest==src && !mem_is_load -> 01, mem_alu
  2) wb_wb_en && wb_dest==src -> 10, wb_data
  3) youngest valid history entry with addr==src -> 11, that entry's data
  4) otherwise -> 00, data 0
- When mem_is_load matches the source, MEM is skipped. Lower levels are still evaluated, but hazard_stall takes effect.
- History: shift register of {valid, addr, data}. On a rising clk edge with wb_wb_en=1 and freeze=0: entry0 <= {1, wb_dest, wb_data}, entry k <= entry k-1, oldest entry dropped.
- With wb_wb_en=0 and freeze=0, the history shifts in an invalid entry, so entries age out after HIST_DEPTH cycles.
- With freeze=1, the history holds.
- Duplicate addresses in history are legal; the youngest entry wins.
- Load-use FSM, states IDLE and LU_STALL:
  - IDLE: hazard = any i with ex_src_vld[i] && mem_wb_en && mem_is_load && mem_dest==ex_src[i] && ex_src[i]!=NO_FWD_REG.
  - hazard_stall = hazard (combinational).
  - If hazard && !freeze, go to LU_STALL.
  - LU_STALL: hazard_stall=0 unconditionally, because the load has moved to WB and is forwarded by rule 2. Return to IDLE on the next non-frozen edge.
  - freeze holds state. Maximum stall per load is exactly one cycle.
- Simultaneous MEM and WB match: MEM wins. WB and history match: WB wins.
- Asserting reset mid-stall aborts the stall immediately. hazard_stall drops asynchronously.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined: adds outputs stat_mem, stat_wb, stat_hist and stat_stall, each 16 bits, saturating at 16'hFFFF.
  - stat_mem, stat_wb and stat_hist increment once per non-frozen cycle in which any operand selects that source.
  - stat_stall increments on each IDLE->LU_STALL transition.
  - All counters clear on reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=0 with mem_wb_en=1, mem_dest=3, ex_src[0]=3 -> sel=00, fwd_data=0, hazard_stall=0. After rst=1 -> sel[0]=01.
- MEM/WB priority: mem_dest=wb_dest=5, both enabled, ex_src[0]=5, mem_alu=0xAA, wb_data=0xBB -> sel[0]=01, fwd_data=0xAA. Drop mem_wb_en -> 10, 0xBB.
- History: WB writes r7=0x11, then the next write is r2=0x22. ex_src[1]=7 one cycle later -> sel=11, data 0x11. After HIST_DEPTH idle cycles -> sel=00.
- Load-use: mem_is_load=1, mem_dest=4, ex_src[0]=4 -> hazard_stall=1 for exactly one cycle. Next cycle with wb_dest=4, wb_data=0x99 -> sel=10, data 0x99, hazard_stall=0.
- PC exclusion: ex_src[0]=15 with MEM/WB writing r15 -> sel=00. No stall even when mem_is_load=1.
- Freeze: freeze=1 during LU_STALL for 3 cycles -> state and history held. Release -> IDLE. With FWD_STATS_EN, stat_stall=1.

Source files
------------

// File: rtl/fwd_unit_param.sv
// rtl/fwd_unit_param.sv - parametrised EX forwarding select with WB history and load-use stall FSM; optional counters under FWD_STATS_EN
module fwd_unit_param #(
  parameter int REG_AW     = 4,
  parameter int DATA_W     = 32,
  parameter int NUM_SRC    = 2,
  parameter int HIST_DEPTH = 2,
  parameter int NO_FWD_REG = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [NUM_SRC-1:0]        ex_src_vld,
  input  logic                      mem_wb_en,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic                      mem_is_load,
  input  logic [DATA_W-1:0]         mem_alu,
  input  logic                      wb_wb_en,
  input  logic [REG_AW-1:0]         wb_dest,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [NUM_SRC*2-1:0]      sel,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic                      hazard_stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]               stat_mem,
  output logic [15:0]               stat_wb,
  output logic [15:0]               stat_hist,
  output logic [15:0]               stat_stall
`endif
);

  // The PC address is never forwarded: its reads always come from the regfile path.
  localparam logic [REG_AW-1:0] NO_FWD_ADDR = REG_AW'(NO_FWD_REG);

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [HIST_DEPTH-1:0]             hist_vld;
  logic [HIST_DEPTH-1:0][REG_AW-1:0] hist_addr;
  logic [HIST_DEPTH-1:0][DATA_W-1:0] hist_data;

  // Any served operand reads the destination of a load still in MEM.
  logic hazard;

  // Retired-write history: entry 0 is youngest; an idle WB shifts in an invalid entry so old writes age out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_vld  <= '0;
      hist_addr <= '0;
      hist_data <= '0;
    end else if (!freeze) begin
      hist_vld[0]  <= wb_wb_en;
      hist_addr[0] <= wb_dest;
      hist_data[0] <= wb_data;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_vld[k]  <= hist_vld[k-1];
        hist_addr[k] <= hist_addr[k-1];
        hist_data[k] <= hist_data[k-1];
      end
    end
  end

  // Per-operand select: MEM (non-load) over WB over youngest history hit over regfile; all zero while in reset
  always_comb begin
    logic [REG_AW-1:0] src;
    logic              hit;
    logic [DATA_W-1:0] hdata;
    sel      = '0;
    fwd_data = '0;
    hazard   = 1'b0;
    src      = '0;
    hit      = 1'b0;
    hdata    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src   = ex_src[i*REG_AW +: REG_AW];
      hit   = 1'b0;
      hdata = '0;
      // Scan oldest to youngest so the youngest matching entry overwrites older ones.
      for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
        if (hist_vld[k] && (hist_addr[k] == src)) begin
          hit   = 1'b1;
          hdata = hist_data[k];
        end
      end
      if (rst && ex_src_vld[i] && (src != NO_FWD_ADDR)) begin
        if (mem_wb_en && (mem_dest == src) && mem_is_load) begin
          hazard = 1'b1;
        end
        if (mem_wb_en && (mem_dest == src) && !mem_is_load) begin
          sel[i*2 +: 2]           = 2'b01;
          fwd_data[i*DATA_W +: DATA_W] = mem_alu;
        end else if (wb_wb_en && (wb_dest == src)) begin
          sel[i*2 +: 2]           = 2'b10;
          fwd_data[i*DATA_W +: DATA_W] = wb_data;
        end else if (hit) begin
          sel[i*2 +: 2]           = 2'b11;
          fwd_data[i*DATA_W +: DATA_W] = hdata;
        end
      end
    end
  end

  // Load-use FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stall only from IDLE; one cycle later the load sits in WB and is forwarded from there
  always_comb begin
    state_nxt    = state;
    hazard_stall = 1'b0;
    case (state)
      IDLE: begin
        hazard_stall = hazard;
        if (hazard && !freeze) begin
          state_nxt = LU_STALL;
        end
      end
      LU_STALL: begin
        if (!freeze) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

`ifdef FWD_STATS_EN
  logic use_mem;
  logic use_wb;
  logic use_hist;

  // Sources picked by at least one operand this cycle
  always_comb begin
    use_mem  = 1'b0;
    use_wb   = 1'b0;
    use_hist = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (sel[i*2 +: 2])
        2'b01:   use_mem  = 1'b1;
        2'b10:   use_wb   = 1'b1;
        2'b11:   use_hist = 1'b1;
        default: ;
      endcase
    end
  end

  // Saturating usage counters; the stall counter counts entries into LU_STALL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_mem   <= '0;
      stat_wb    <= '0;
      stat_hist  <= '0;
      stat_stall <= '0;
    end else if (!freeze) begin
      if (use_mem && (stat_mem != 16'hFFFF)) begin
        stat_mem <= stat_mem + 16'd1;
      end
      if (use_wb && (stat_wb != 16'hFFFF)) begin
        stat_wb <= stat_wb + 16'd1;
      end
      if (use_hist && (stat_hist != 16'hFFFF)) begin
        stat_hist <= stat_hist + 16'd1;
      end
      if ((state == IDLE) && hazard && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_unit_param.sv
// tb/tb_fwd_unit_param.sv - self-checking bench for fwd_unit_param with a queue-based reference model
module tb_fwd_unit_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic [7:0]  ex_src = '0;
  logic [1:0]  ex_src_vld = '0;
  logic        mem_wb_en = 1'b0;
  logic [3:0]  mem_dest = '0;
  logic        mem_is_load = 1'b0;
  logic [31:0] mem_alu = '0;
  logic        wb_wb_en = 1'b0;
  logic [3:0]  wb_dest = '0;
  logic [31:0] wb_data = '0;
  logic [3:0]  sel;
  logic [63:0] fwd_data;
  logic        hazard_stall;
`ifdef FWD_STATS_EN
  logic [15:0] stat_mem, stat_wb, stat_hist, stat_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  fwd_unit_param #(
    .REG_AW(4), .DATA_W(32), .NUM_SRC(2), .HIST_DEPTH(2), .NO_FWD_REG(15)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .ex_src(ex_src), .ex_src_vld(ex_src_vld),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_is_load(mem_is_load), .mem_alu(mem_alu),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .sel(sel), .fwd_data(fwd_data), .hazard_stall(hazard_stall)
`ifdef FWD_STATS_EN
    , .stat_mem(stat_mem), .stat_wb(stat_wb), .stat_hist(stat_hist), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: history is a list of the last two WB slots (youngest first),
  // m_stalled remembers whether the previous live cycle already stalled.
  typedef struct packed {
    logic        vld;
    logic [3:0]  addr;
    logic [31:0] data;
  } hent_t;

  hent_t       m_hist[$];
  bit          m_stalled;
  int          m_mem, m_wb, m_hist_cnt, m_stall;
  logic [3:0]  e_sel;
  logic [63:0] e_data;
  logic        e_stall;

  function automatic void model_clear();
    m_hist.delete();
    m_stalled  = 1'b0;
    m_mem      = 0;
    m_wb       = 0;
    m_hist_cnt = 0;
    m_stall    = 0;
  endfunction

  function automatic void model_outputs();
    logic [3:0] s;
    bit found;
    e_sel   = '0;
    e_data  = '0;
    e_stall = 1'b0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        s = ex_src[i*4 +: 4];
        if (ex_src_vld[i] && s != 4'd15) begin
          if (mem_wb_en && mem_dest == s && mem_is_load && !m_stalled) e_stall = 1'b1;
          if (mem_wb_en && mem_dest == s && !mem_is_load) begin
            e_sel[i*2 +: 2] = 2'd1; e_data[i*32 +: 32] = mem_alu;
          end else if (wb_wb_en && wb_dest == s) begin
            e_sel[i*2 +: 2] = 2'd2; e_data[i*32 +: 32] = wb_data;
          end else begin
            found = 1'b0;
            foreach (m_hist[k]) begin
              if (!found && m_hist[k].vld && m_hist[k].addr == s) begin
                found = 1'b1;
                e_sel[i*2 +: 2] = 2'd3; e_data[i*32 +: 32] = m_hist[k].data;
              end
            end
          end
        end
      end
    end
  endfunction

  task automatic tick();
    bit um, uw, uh;
    model_outputs();
    if (rst && !freeze) begin
      um = 0; uw = 0; uh = 0;
      for (int i = 0; i < 2; i++) begin
        if (e_sel[i*2 +: 2] == 2'd1) um = 1;
        if (e_sel[i*2 +: 2] == 2'd2) uw = 1;
        if (e_sel[i*2 +: 2] == 2'd3) uh = 1;
      end
      if (um && m_mem < 65535) m_mem++;
      if (uw && m_wb < 65535) m_wb++;
      if (uh && m_hist_cnt < 65535) m_hist_cnt++;
      if (e_stall && m_stall < 65535) m_stall++;
      m_stalled = e_stall;
      m_hist.push_front({wb_wb_en, wb_dest, wb_data});
      if (m_hist.size() > 2) void'(m_hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    freeze = 0; ex_src = '0; ex_src_vld = '0;
    mem_wb_en = 0; mem_dest = '0; mem_is_load = 0; mem_alu = '0;
    wb_wb_en = 0; wb_dest = '0; wb_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_clear();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    mem_wb_en = 1; mem_dest = 4'd3; mem_alu = 32'h1234; ex_src[3:0] = 4'd3; ex_src_vld = 2'b01;
    #1;
    vectors++;
    if (sel !== 4'b0 || fwd_data !== 64'b0 || hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs sel=%b data=%h stall=%b exp 0/0/0", sel, fwd_data, hazard_stall);
    end
    model_clear();
    rst = 1'b1;
    #1;
    vectors++;
    if (sel[1:0] !== 2'b01 || fwd_data[31:0] !== 32'h1234) begin
      miscompares++;
      $display("FAIL reset_release sel=%b data=%h exp 01/00001234", sel[1:0], fwd_data[31:0]);
    end
  endtask

  task automatic test_priority();
    do_reset();
    clear_inputs();
    mem_wb_en = 1; mem_dest = 4'd5; mem_alu = 32'hAA;
    wb_wb_en = 1; wb_dest = 4'd5; wb_data = 32'hBB;
    ex_src[3:0] = 4'd5; ex_src_vld = 2'b01;
    #1;
    vectors++;
    if (sel[1:0] !== 2'b01 || fwd_data[31:0] !== 32'hAA) begin
      miscompares++;
      $display("FAIL prio_mem sel=%b data=%h exp 01/000000aa", sel[1:0], fwd_data[31:0]);
    end
    mem_wb_en = 0;
    #1;
    vectors++;
    if (sel[1:0] !== 2'b10 || fwd_data[31:0] !== 32'hBB) begin
      miscompares++;
      $display("FAIL prio_wb sel=%b data=%h exp 10/000000bb", sel[1:0], fwd_data[31:0]);
    end
    ex_src_vld = 2'b00;
    #1;
    vectors++;
    if (sel !== 4'b0 || fwd_data !== 64'b0) begin
      miscompares++;
      $display("FAIL prio_unread sel=%b data=%h exp 0/0", sel, fwd_data);
    end
  endtask

  task automatic test_history();
    do_reset();
    clear_inputs();
    wb_wb_en = 1; wb_dest = 4'd7; wb_data = 32'h11;
    tick();
    wb_dest = 4'd2; wb_data = 32'h22;
    tick();
    wb_wb_en = 0; ex_src[7:4] = 4'd7; ex_src_vld = 2'b10;
    #1;
    vectors++;
    if (sel[3:2] !== 2'b11 || fwd_data[63:32] !== 32'h11) begin
      miscompares++;
      $display("FAIL hist_hit sel=%b data=%h exp 11/00000011", sel[3:2], fwd_data[63:32]);
    end
    tick();
    tick();
    vectors++;
    if (sel !== 4'b0 || fwd_data !== 64'b0) begin
      miscompares++;
      $display("FAIL hist_age sel=%b data=%h exp 0/0", sel, fwd_data);
    end
    wb_wb_en = 1; wb_dest = 4'd7; wb_data = 32'h11;
    tick();
    wb_data = 32'h33;
    tick();
    wb_wb_en = 0;
    #1;
    vectors++;
    if (sel[3:2] !== 2'b11 || fwd_data[63:32] !== 32'h33) begin
      miscompares++;
      $display("FAIL hist_youngest sel=%b data=%h exp 11/00000033", sel[3:2], fwd_data[63:32]);
    end
    wb_wb_en = 1; wb_data = 32'h44;
    #1;
    vectors++;
    if (sel[3:2] !== 2'b10 || fwd_data[63:32] !== 32'h44) begin
      miscompares++;
      $display("FAIL hist_wb_wins sel=%b data=%h exp 10/00000044", sel[3:2], fwd_data[63:32]);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    clear_inputs();
    mem_wb_en = 1; mem_is_load = 1; mem_dest = 4'd4; mem_alu = 32'hDEAD;
    ex_src[3:0] = 4'd4; ex_src_vld = 2'b01;
    #1;
    vectors++;
    if (hazard_stall !== 1'b1 || sel[1:0] !== 2'b00) begin
      miscompares++;
      $display("FAIL lu_stall stall=%b sel=%b exp 1/00", hazard_stall, sel[1:0]);
    end
    tick();
    wb_wb_en = 1; wb_dest = 4'd4; wb_data = 32'h99;
    #1;
    vectors++;
    if (sel[1:0] !== 2'b10 || fwd_data[31:0] !== 32'h99 || hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_forward sel=%b data=%h stall=%b exp 10/00000099/0", sel[1:0], fwd_data[31:0], hazard_stall);
    end
    tick();
    wb_wb_en = 0;
    #1;
    vectors++;
    if (hazard_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_next_load stall=%b exp 1", hazard_stall);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_async_drop stall=%b exp 0", hazard_stall);
    end
    model_clear();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    model_clear();
    rst = 1'b1;
    #1;
    vectors++;
    if (hazard_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_abort_stall stall=%b exp 1", hazard_stall);
    end
  endtask

  task automatic test_pc_exclusion();
    do_reset();
    clear_inputs();
    mem_wb_en = 1; mem_dest = 4'd15; mem_alu = 32'h55;
    wb_wb_en = 1; wb_dest = 4'd15; wb_data = 32'h66;
    ex_src = {4'd15, 4'd15}; ex_src_vld = 2'b11;
    #1;
    vectors++;
    if (sel !== 4'b0 || fwd_data !== 64'b0) begin
      miscompares++;
      $display("FAIL pc_sel sel=%b data=%h exp 0/0", sel, fwd_data);
    end
    mem_is_load = 1;
    #1;
    vectors++;
    if (hazard_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL pc_no_stall stall=%b exp 0", hazard_stall);
    end
    tick();
    mem_wb_en = 0; wb_wb_en = 0;
    #1;
    vectors++;
    if (sel !== 4'b0 || fwd_data !== 64'b0) begin
      miscompares++;
      $display("FAIL pc_hist sel=%b data=%h exp 0/0", sel, fwd_data);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    clear_inputs();
    wb_wb_en = 1; wb_dest = 4'd9; wb_data = 32'h5A;
    tick();
    wb_wb_en = 0;
    mem_wb_en = 1; mem_is_load = 1; mem_dest = 4'd4;
    ex_src = {4'd9, 4'd4}; ex_src_vld = 2'b11;
    #1;
    vectors++;
    if (hazard_stall !== 1'b1 || sel[3:2] !== 2'b11 || fwd_data[63:32] !== 32'h5A) begin
      miscompares++;
      $display("FAIL frz_setup stall=%b sel=%b data=%h exp 1/11/0000005a", hazard_stall, sel[3:2], fwd_data[63:32]);
    end
    tick();
    freeze = 1; wb_wb_en = 1; wb_dest = 4'd10; wb_data = 32'h77;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (hazard_stall !== 1'b0 || sel[3:2] !== 2'b11 || fwd_data[63:32] !== 32'h5A) begin
        miscompares++;
        $display("FAIL frz_hold[%0d] stall=%b sel=%b data=%h exp 0/11/0000005a", c, hazard_stall, sel[3:2], fwd_data[63:32]);
      end
    end
    freeze = 0; wb_wb_en = 0;
    tick();
    vectors++;
    if (hazard_stall !== 1'b1 || sel[3:2] !== 2'b00) begin
      miscompares++;
      $display("FAIL frz_release stall=%b sel=%b exp 1/00", hazard_stall, sel[3:2]);
    end
`ifdef FWD_STATS_EN
    vectors++;
    if (stat_stall !== 16'd1) begin
      miscompares++;
      $display("FAIL frz_stat_stall got=%0d exp 1", stat_stall);
    end
`endif
  endtask

  function automatic logic [3:0] rand_addr();
    logic [3:0] a;
    if ($urandom_range(0, 9) == 0) a = 4'd15;
    else a = 4'($urandom_range(0, 4));
    return a;
  endfunction

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      freeze      = ($urandom_range(0, 99) < 15);
      ex_src      = {rand_addr(), rand_addr()};
      ex_src_vld  = 2'($urandom);
      mem_wb_en   = 1'($urandom);
      mem_dest    = rand_addr();
      mem_is_load = ($urandom_range(0, 3) == 0);
      mem_alu     = $urandom;
      wb_wb_en    = 1'($urandom);
      wb_dest     = rand_addr();
      wb_data     = $urandom;
      #1;
      model_outputs();
      vectors++;
      if (sel !== e_sel || fwd_data !== e_data || hazard_stall !== e_stall) begin
        miscompares++;
        $display("FAIL rand[%0d] sel=%b data=%h stall=%b exp sel=%b data=%h stall=%b",
                 n, sel, fwd_data, hazard_stall, e_sel, e_data, e_stall);
      end
      tick();
    end
`ifdef FWD_STATS_EN
    vectors++;
    if (stat_mem !== 16'(m_mem) || stat_wb !== 16'(m_wb) || stat_hist !== 16'(m_hist_cnt) || stat_stall !== 16'(m_stall)) begin
      miscompares++;
      $display("FAIL rand_stats got=%0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               stat_mem, stat_wb, stat_hist, stat_stall, m_mem, m_wb, m_hist_cnt, m_stall);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_priority();
    test_history();
    test_load_use();
    test_pc_exclusion();
    test_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
